// File: rtl/artec_dma_pkg.sv
// Shared types and constants for the DMA channel front end.
// The task word carries the beat count of its burst in bits [ARB_DATA_NUM_LSB +: CNT_W].
package artec_dma_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_TASK,
        ARB_DATA
    } arb_state_t;

    localparam int ARB_DATA_NUM_LSB = 32;

    typedef struct packed {
        logic [25:0] info;
        logic [5:0]  data_num;
        logic [31:0] addr;
    } ch_task_o_t;

endpackage

// File: rtl/artec_rr_picker.sv
// Round-robin picker: first set bit of req_i at or after start_i, wrapping modulo N.
// Returns the winner both one-hot and as an index, plus a flag when any bit is set.
module artec_rr_picker #(
    parameter int N = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] pos;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = '0;
        for (int k = 0; k < N; k++) begin
            pos = IW'((int'(start_i) + k) % N);
            if (!any_o && req_i[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule

// File: rtl/artec_dma_channel_arbiter.sv
// Shares one AXI write front end between NUM_CH channel buffers: grant a channel,
// forward its task, forward exactly data_num data beats, then release the grant.
module artec_dma_channel_arbiter
    import artec_dma_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TASK_W     = 64,
    parameter int DATA_W     = 512,
    parameter int CNT_W      = 6,
    parameter int REQ_WIDTH  = 8,
    parameter int URGENT_THR = 8,
    localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_i,
    input  logic [NUM_CH-1:0]             ch_enable_i,
    input  logic [NUM_CH*REQ_WIDTH-1:0]   occ_i,
    input  logic [NUM_CH-1:0]             task_valid_i,
    output logic [NUM_CH-1:0]             task_ready_o,
    input  logic [NUM_CH*TASK_W-1:0]      task_data_i,
    input  logic [NUM_CH-1:0]             data_valid_i,
    output logic [NUM_CH-1:0]             data_ready_o,
    input  logic [NUM_CH*DATA_W-1:0]      data_i,
    output logic                          task_valid_o,
    input  logic                          task_ready_i,
    output logic [TASK_W-1:0]             task_data_o,
    output logic                          data_valid_o,
    input  logic                          data_ready_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          data_last_o,
    output logic [ID_W-1:0]               grant_id_o,
    output logic                          busy_o,
    output logic                          err_zero_len_o
);

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   grant_q, grant_d;
    logic [NUM_CH-1:0] grant_oh_q, grant_oh_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;

    logic [NUM_CH-1:0] req, urgent;
    logic [NUM_CH-1:0] urg_gnt, norm_gnt;
    logic [ID_W-1:0]   urg_idx, norm_idx;
    logic              urg_any, norm_any;

    logic              sel_task_valid, sel_data_valid;
    logic [TASK_W-1:0] sel_task_data;
    logic [DATA_W-1:0] sel_data;
    logic [CNT_W-1:0]  task_num;
    logic [CNT_W:0]    len_m1;
    logic              last_beat, task_hs, data_hs;
    logic [ID_W-1:0]   next_ptr;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            req[c]    = task_valid_i[c] && ch_enable_i[c];
            urgent[c] = req[c] && (occ_i[c*REQ_WIDTH +: REQ_WIDTH] >= REQ_WIDTH'(URGENT_THR));
        end
    end

    artec_rr_picker #(.N(NUM_CH)) u_pick_urgent (
        .req_i   (urgent),
        .start_i (rr_ptr_q),
        .gnt_o   (urg_gnt),
        .idx_o   (urg_idx),
        .any_o   (urg_any)
    );

    artec_rr_picker #(.N(NUM_CH)) u_pick_normal (
        .req_i   (req),
        .start_i (rr_ptr_q),
        .gnt_o   (norm_gnt),
        .idx_o   (norm_idx),
        .any_o   (norm_any)
    );

    // Source mux for the granted channel; grant_q is stable for the whole burst.
    always_comb begin
        sel_task_valid = 1'b0;
        sel_task_data  = '0;
        sel_data_valid = 1'b0;
        sel_data       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (grant_q == ID_W'(c)) begin
                sel_task_valid = task_valid_i[c];
                sel_task_data  = task_data_i[c*TASK_W +: TASK_W];
                sel_data_valid = data_valid_i[c];
                sel_data       = data_i[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        task_valid_o = (state_q == ARB_TASK) && sel_task_valid;
        task_data_o  = (state_q == ARB_TASK) ? sel_task_data : '0;
        task_ready_o = (state_q == ARB_TASK && task_ready_i) ? grant_oh_q : '0;
        data_valid_o = (state_q == ARB_DATA) && sel_data_valid;
        data_o       = (state_q == ARB_DATA) ? sel_data : '0;
        data_ready_o = (state_q == ARB_DATA && data_ready_i) ? grant_oh_q : '0;
    end

    // len-1 is formed one bit wider so the compare cannot wrap.
    assign task_num       = sel_task_data[ARB_DATA_NUM_LSB +: CNT_W];
    assign len_m1         = {1'b0, len_q} - (CNT_W + 1)'(1);
    assign last_beat      = ({1'b0, beat_cnt_q} == len_m1);
    assign task_hs        = task_valid_o && task_ready_i;
    assign data_hs        = data_valid_o && data_ready_i;
    assign data_last_o    = data_valid_o && last_beat;
    assign next_ptr       = (grant_q == ID_W'(NUM_CH - 1)) ? '0 : grant_q + ID_W'(1);
    assign grant_id_o     = grant_q;
    assign busy_o         = (state_q != ARB_IDLE);
    assign err_zero_len_o = err_q;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        rr_ptr_d   = rr_ptr_q;
        len_d      = len_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;
        if (clear_i) begin
            state_d    = ARB_IDLE;
            beat_cnt_d = '0;
            rr_ptr_d   = '0;
            err_d      = 1'b0;
        end else begin
            unique case (state_q)
                ARB_IDLE: begin
                    if (norm_any) begin
                        grant_d    = urg_any ? urg_idx : norm_idx;
                        grant_oh_d = urg_any ? urg_gnt : norm_gnt;
                        state_d    = ARB_TASK;
                    end
                end
                ARB_TASK: begin
                    if (task_hs) begin
                        len_d      = task_num;
                        beat_cnt_d = '0;
                        if (task_num == '0) begin
                            err_d   = 1'b1;
                            state_d = ARB_IDLE;
                        end else begin
                            state_d = ARB_DATA;
                        end
                    end
                end
                ARB_DATA: begin
                    if (data_hs) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                        if (last_beat) begin
                            rr_ptr_d = next_ptr;
                            state_d  = ARB_IDLE;
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            grant_oh_q <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            rr_ptr_q   <= rr_ptr_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_artec_dma_channel_arbiter.sv
// Directed-plus-random bench for artec_dma_channel_arbiter against a transaction-level
// model of the grant order (urgent-first round robin) and of each burst's beats.
module tb_artec_dma_channel_arbiter;

    localparam int N   = 4;
    localparam int TW  = 64;
    localparam int DW  = 512;
    localparam int CW  = 6;
    localparam int RW  = 8;
    localparam int THR = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic            clear_i;
    logic [N-1:0]    ch_enable_i;
    logic [N*RW-1:0] occ_i;
    logic [N-1:0]    task_valid_i;
    logic [N-1:0]    task_ready_o;
    logic [N*TW-1:0] task_data_i;
    logic [N-1:0]    data_valid_i;
    logic [N-1:0]    data_ready_o;
    logic [N*DW-1:0] data_i;
    logic            task_valid_o;
    logic            task_ready_i;
    logic [TW-1:0]   task_data_o;
    logic            data_valid_o;
    logic            data_ready_i;
    logic [DW-1:0]   data_o;
    logic            data_last_o;
    logic [1:0]      grant_id_o;
    logic            busy_o;
    logic            err_zero_len_o;

    artec_dma_channel_arbiter #(
        .NUM_CH(N), .TASK_W(TW), .DATA_W(DW), .CNT_W(CW), .REQ_WIDTH(RW), .URGENT_THR(THR)
    ) dut (
        .clk(clk), .rst(rst), .clear_i(clear_i), .ch_enable_i(ch_enable_i), .occ_i(occ_i),
        .task_valid_i(task_valid_i), .task_ready_o(task_ready_o), .task_data_i(task_data_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .task_valid_o(task_valid_o), .task_ready_i(task_ready_i), .task_data_o(task_data_o),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i), .data_o(data_o),
        .data_last_o(data_last_o), .grant_id_o(grant_id_o), .busy_o(busy_o),
        .err_zero_len_o(err_zero_len_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Channel source state and reference model state.
    bit          pend [N];
    int          tnum [N];
    logic [31:0] taddr[N];
    logic [25:0] tinfo[N];
    int          occ  [N];
    bit          en   [N];
    int          bidx [N];
    logic [31:0] salt [N];
    int          m_rr  = 0;
    bit          m_err = 1'b0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] beat(input int c, input int b, input logic [31:0] s);
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++)
            v[i*32 +: 32] = s ^ 32'(c << 28) ^ 32'(b << 8) ^ 32'(i) ^ 32'(i << 20);
        return v;
    endfunction

    function automatic logic [TW-1:0] tword(input int c);
        return {tinfo[c], 6'(tnum[c]), taddr[c]};
    endfunction

    // Urgent-first round robin from the model's pointer; -1 when nothing is eligible.
    function automatic int model_pick();
        bit any_urg = 1'b0;
        int c;
        for (int i = 0; i < N; i++)
            if (pend[i] && en[i] && occ[i] >= THR) any_urg = 1'b1;
        for (int k = 0; k < N; k++) begin
            c = (m_rr + k) % N;
            if (pend[c] && en[c] && (!any_urg || occ[c] >= THR)) return c;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int c = 0; c < N; c++) begin
            task_valid_i[c]          = pend[c];
            ch_enable_i[c]           = en[c];
            task_data_i[c*TW +: TW]  = tword(c);
            occ_i[c*RW +: RW]        = 8'(occ[c]);
            data_i[c*DW +: DW]       = beat(c, bidx[c], salt[c]);
        end
    endtask

    task automatic new_task(input int c, input int n, input int o);
        pend[c]  = 1'b1;
        tnum[c]  = n;
        taddr[c] = $urandom;
        tinfo[c] = 26'($urandom);
        occ[c]   = o;
        en[c]    = 1'b1;
        bidx[c]  = 0;
        salt[c]  = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_pulse();
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        m_rr  = 0;
        m_err = 1'b0;
    endtask

    task automatic idle_checks();
        chk("idle_busy", busy_o, 0);
        chk("idle_task_valid", task_valid_o, 0);
        chk("idle_task_data", task_data_o, 0);
        chk("idle_task_ready", task_ready_o, 0);
        chk("idle_data_valid", data_valid_o, 0);
        chk("idle_data", data_o, 0);
        chk("idle_data_ready", data_ready_o, 0);
        chk("err_flag", err_zero_len_o, m_err);
    endtask

    // One full transaction: grant, task handshake, data beats. rmode: 0 always ready,
    // 1 ready toggling 1,0,..., 2 random valid/ready. abort_kind 0 = clear_i, 1 = rst.
    task automatic serve(input int exp_ch, input int rmode, input int abort_at, input int abort_kind);
        int g, b, cyc;
        bit dv, dr;
        logic [N-1:0] oh;
        drive();
        #1;
        idle_checks();
        g = model_pick();
        if (g < 0) return;
        oh = N'(1) << g;
        step();
        chk("task_busy", busy_o, 1);
        chk("grant_id", grant_id_o, g);
        if (exp_ch >= 0) chk("grant_expected", grant_id_o, exp_ch);
        for (int s = int'($urandom_range(0, 2)); s > 0; s--) begin
            chk("task_hold_valid", task_valid_o, 1);
            chk("task_hold_ready", task_ready_o, 0);
            chk("task_hold_data", task_data_o, tword(g));
            step();
        end
        task_ready_i = 1'b1;
        #1;
        chk("task_valid", task_valid_o, 1);
        chk("task_data", task_data_o, tword(g));
        chk("task_ready_route", task_ready_o, oh);
        chk("task_no_data_ready", data_ready_o, 0);
        step();
        task_ready_i = 1'b0;
        pend[g] = 1'b0;
        drive();
        if (tnum[g] == 0) begin
            #1;
            m_err = 1'b1;
            chk("zero_len_idle", busy_o, 0);
            chk("zero_len_err", err_zero_len_o, 1);
            chk("zero_len_no_data", data_valid_o, 0);
            return;
        end
        b = 0;
        cyc = 0;
        while (b < tnum[g] && cyc < 400) begin
            cyc++;
            if (abort_at >= 0 && b == abort_at) begin
                data_valid_i    = '0;
                data_valid_i[g] = 1'b1;
                data_ready_i    = 1'b1;
                drive();
                if (abort_kind == 0) begin
                    clear_i = 1'b1;
                    step();
                    clear_i = 1'b0;
                    #1;
                    chk("abort_busy", busy_o, 0);
                    chk("abort_task_ready", task_ready_o, 0);
                    chk("abort_data_ready", data_ready_o, 0);
                    chk("abort_err", err_zero_len_o, 0);
                end else begin
                    #2;
                    rst = 1'b1;
                    #1;
                    chk("rst_busy", busy_o, 0);
                    chk("rst_data_valid", data_valid_o, 0);
                    chk("rst_data_ready", data_ready_o, 0);
                    chk("rst_data_last", data_last_o, 0);
                    chk("rst_grant", grant_id_o, 0);
                    chk("rst_err", err_zero_len_o, 0);
                    step();
                    rst = 1'b0;
                end
                m_rr  = 0;
                m_err = 1'b0;
                bidx[g] = 0;
                data_valid_i = '0;
                data_ready_i = 1'b0;
                return;
            end
            dv = (rmode == 2) ? ($urandom % 4 != 0) : 1'b1;
            dr = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 1) : ($urandom % 3 != 0);
            if (rmode == 2) en[g] = ($urandom % 2 == 0);
            data_valid_i    = N'($urandom);
            data_valid_i[g] = dv;
            data_ready_i    = dr;
            drive();
            #1;
            chk("data_valid", data_valid_o, dv);
            if (dv) chk("data_beat", data_o, beat(g, b, salt[g]));
            chk("data_last", data_last_o, (dv && b == tnum[g] - 1));
            chk("data_ready_route", data_ready_o, dr ? oh : '0);
            chk("data_grant_stable", grant_id_o, g);
            chk("data_task_ready", task_ready_o, 0);
            step();
            if (dv && dr) begin
                b++;
                bidx[g] = b;
            end
        end
        chk("beats_done", b, tnum[g]);
        data_valid_i = '0;
        data_ready_i = 1'b0;
        bidx[g] = 0;
        drive();
        #1;
        chk("release_busy", busy_o, 0);
        m_rr = (g + 1) % N;
    endtask

    int ord[5] = '{0, 1, 2, 3, 0};

    initial begin
        rst          = 1'b1;
        clear_i      = 1'b0;
        task_ready_i = 1'b0;
        data_ready_i = 1'b0;
        data_valid_i = '0;
        for (int c = 0; c < N; c++) begin
            pend[c] = 1'b0; tnum[c] = 1; taddr[c] = '0; tinfo[c] = '0;
            occ[c] = 0; en[c] = 1'b1; bidx[c] = 0; salt[c] = '0;
        end
        drive();
        #1;
        chk("reset_busy", busy_o, 0);
        chk("reset_task_valid", task_valid_o, 0);
        chk("reset_task_ready", task_ready_o, 0);
        chk("reset_data_valid", data_valid_o, 0);
        chk("reset_data_ready", data_ready_o, 0);
        chk("reset_grant", grant_id_o, 0);
        chk("reset_err", err_zero_len_o, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single channel, four beats.
        new_task(0, 4, 1);
        serve(0, 0, -1, 0);

        // Round robin over four equally loaded channels.
        clear_pulse();
        for (int c = 0; c < N; c++) new_task(c, 2, 1);
        for (int k = 0; k < 5; k++) begin
            serve(ord[k], 0, -1, 0);
            if (k == 0) new_task(0, 2, 1);
        end

        // Urgent channel jumps the round-robin order.
        clear_pulse();
        new_task(1, 3, 2);
        new_task(3, 2, 9);
        serve(3, 2, -1, 0);
        serve(1, 2, -1, 0);

        // Alternating backpressure on an eight-beat burst.
        new_task(2, 8, 1);
        serve(2, 1, -1, 0);

        // Zero-length task sets the sticky flag; clear drops it.
        new_task(2, 0, 1);
        serve(2, 0, -1, 0);
        clear_pulse();
        chk("err_cleared", err_zero_len_o, 0);

        // Abort mid-burst, then the pointer must restart from channel 0.
        new_task(2, 1, 1);
        serve(2, 0, -1, 0);
        new_task(0, 6, 1);
        serve(0, 0, 3, 0);
        new_task(1, 2, 1);
        new_task(3, 2, 1);
        serve(1, 0, -1, 0);
        serve(3, 0, -1, 0);

        // Random traffic, occupancy, enables and handshakes.
        for (int t = 0; t < 30; t++) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && $urandom % 2 == 0)
                    new_task(c, ($urandom % 10 == 0) ? 0 : int'($urandom_range(1, 5)),
                             int'($urandom_range(0, 12)));
                en[c] = ($urandom % 4 != 0);
            end
            if (model_pick() < 0) begin
                for (int c = 0; c < N; c++) en[c] = 1'b1;
                if (model_pick() < 0) new_task(int'($urandom_range(0, N - 1)), 3, 4);
            end
            serve(-1, 2, -1, 0);
        end

        // Asynchronous reset in the middle of a burst.
        for (int c = 0; c < N; c++) begin
            pend[c] = 1'b0;
            en[c]   = 1'b1;
        end
        new_task(3, 5, 1);
        serve(3, 0, 2, 1);
        new_task(2, 1, 1);
        serve(2, 0, -1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/artec_dma_channel_arbiter.md
Name: artec_dma_channel_arbiter

Overview:
- Shares one AXI write-master front end between NUM_CH DMA channel buffers.
- Each channel presents a task stream (address, beat count, info) and a data stream.
- The arbiter picks one channel with a pending task, forwards that task, then forwards exactly data_num data beats from the same channel, then releases the grant.
- Sits between the per-channel buffers and the AXI burst generator; uses per-channel occupancy for urgency priority.

Parameters:
- NUM_CH, 4, number of channels (2..16).
- TASK_W, 64, width of packed ch_task_o_t.
- DATA_W, 512, data beat width.
- CNT_W, 6, width of task data_num field; data_num occupies task bits [CNT_W+31:32].
- REQ_WIDTH, 8, width of per-channel occupancy input.
- URGENT_THR, 8, occupancy at or above which a channel is urgent.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- clear_i  in  1  synchronous abort and return to idle
- ch_enable_i  in  NUM_CH  per-channel arbitration enable
- occ_i  in  NUM_CH*REQ_WIDTH  per-channel task FIFO occupancy
- task_valid_i  in  NUM_CH  channel task valid
- task_ready_o  out  NUM_CH  channel task ready
- task_data_i  in  NUM_CH*TASK_W  channel tasks
- data_valid_i  in  NUM_CH  channel data valid
- data_ready_o  out  NUM_CH  channel data ready
- data_i  in  NUM_CH*DATA_W  channel data
- task_valid_o  out  1  granted task valid
- task_ready_i  in  1  downstream task ready
- task_data_o  out  TASK_W  granted task
- data_valid_o  out  1  granted data valid
- data_ready_i  in  1  downstream data ready
- data_o  out  DATA_W  granted data
- data_last_o  out  1  final beat of current task
- grant_id_o  out  $clog2(NUM_CH)  channel currently granted
- busy_o  out  1  high when FSM is not IDLE
- err_zero_len_o  out  1  sticky flag; a task with data_num==0 was seen

Behaviour:
- Reset values: all valid and ready outputs 0, grant_id_o 0, busy_o 0, err_zero_len_o 0, rr_ptr 0, FSM in IDLE.
- Eligibility: req[i] = task_valid_i[i] && ch_enable_i[i]. urgent[i] = req[i] && occ_i[i] >= URGENT_THR.
- Arbitration:
  - If any channel is urgent, round-robin over urgent channels only; otherwise round-robin over req.
  - Search starts at rr_ptr and wraps modulo NUM_CH.
  - The decision is registered into grant_id.
- FSM IDLE: if any req, latch grant and go to TASK next cycle; otherwise stay.
- FSM TASK:
  - task_valid_o = task_valid_i[grant]; task_data_o = task_data_i[grant]; task_ready_o[grant] = task_ready_i. All other readies are 0.
  - On handshake, latch len = data_num and clear beat_cnt.
  - If len==0: set err_zero_len_o and go to IDLE.
  - Otherwise go to DATA.
  - If the granted channel drops task_valid, hold TASK; do not re-arbitrate.
- FSM DATA:
  - Combinational pass-through: data_valid_o = data_valid_i[grant]; data_o = data_i[grant]; data_ready_o[grant] = data_ready_i.
  - data_last_o = (beat_cnt == len-1) && data_valid_o.
  - beat_cnt increments on each handshake.
  - On the last handshake: rr_ptr = (grant+1) mod NUM_CH, then go to IDLE.
- Latency and throughput:
  - Grant to task valid: 1 cycle.
  - Task handshake to first data beat accepted: 1 cycle minimum.
  - One IDLE bubble between consecutive tasks.
- Outside TASK/DATA, no channel receives ready. Task and data outputs are 0 in IDLE.
- ch_enable_i deassertion for the granted channel mid-task does not abort; it only blocks new grants.
- clear_i:
  - Forces IDLE next cycle, zeroes beat_cnt and rr_ptr, and clears err_zero_len_o.
  - Takes priority over any handshake in the same cycle; the in-flight burst is abandoned.
  - Channels are cleared by the same system clear.
- Asynchronous rst mid-burst: all outputs return to their reset values immediately.
- Width rules: beat_cnt is CNT_W bits. Comparison uses len-1 computed at CNT_W+1 bits to avoid wrap.
- grant_id_o is held stable for the whole TASK+DATA window.

Decomposition:
- artec_dma_pkg additions:
  - arb_state_t enum {ARB_IDLE, ARB_TASK, ARB_DATA}.
  - Reuse ch_task_o_t for task_data.
  - Constant ARB_DATA_NUM_LSB = 32.
- One sub-module: artec_rr_picker (parameter N). Inputs: req mask, start pointer. Outputs: one-hot grant, index, any. Instantiated twice (urgent mask and normal mask); the urgent result is selected when urgent is nonzero.

Test Plan:
- Single channel: ch0 task data_num=4, downstream always ready → task_valid_o 1 cycle after req. 4 data beats with grant_id_o=0. data_last_o only on beat 4. busy_o drops the following cycle.
- Round-robin fairness: ch0..ch3 all hold tasks of data_num=2, occ_i=1 each → grant order 0,1,2,3,0. rr_ptr wraps from 3 to 0.
- Urgency: ch1 occ=2, ch3 occ=9, rr_ptr=0, URGENT_THR=8 → ch3 is granted first, then ch1.
- Backpressure: data_ready_i toggles 1,0,1,0 on an 8-beat task → exactly 8 handshakes. data_o is stable while valid && !ready. Other channels' readies stay 0.
- Zero-length task: ch2 data_num=0 → task is consumed, err_zero_len_o=1, FSM returns to IDLE without entering DATA. A subsequent clear_i returns the flag to 0.
- Abort: clear_i asserted at beat 3 of 6 → next cycle busy_o=0, all readies 0, rr_ptr=0. A fresh task on ch1 is then granted normally.
